// File: rtl/cache_sched_pkg.sv
// Shared types and constants for the row-cache request scheduler.
package cache_sched_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned CH_W_DEF   = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    MISS,
    FILL,
    DONE
  } state_t;

  // Saturating increment for the access statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  input  logic [IDXW-1:0] adv_idx,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDXW-1:0] idx_c,
  output logic            any_c
);

  logic [IDXW-1:0] rr_ptr;
  int unsigned     cand;

  // Scan requesters starting at the pointer, wrapping, and pick the first one.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr) + i) % NREQ;
      if (!any_c && req[IDXW'(cand)]) begin
        any_c              = 1'b1;
        gnt_c[IDXW'(cand)] = 1'b1;
        idx_c              = IDXW'(cand);
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (adv) begin
      rr_ptr <= (adv_idx == IDXW'(NREQ - 1)) ? '0 : adv_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/cache_sched.sv
// Serialises requester row accesses onto the row cache command port and
// emulates DRAM fill latency on a cache miss.
module cache_sched
  import cache_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ADDRWIDTH = ADDR_W_DEF,
  parameter int unsigned CHWIDTH   = CH_W_DEF,
  parameter int unsigned MISS_LAT  = 8,
  parameter int unsigned CHECK_WIN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*ADDRWIDTH-1:0] req_row,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [CHWIDTH-1:0]        rsp_crow,
  output logic                      rsp_miss,
  output logic                      RD,
  output logic                      WR,
  output logic [ADDRWIDTH-1:0]      RowId,
  output logic                      sync,
  input  logic                      hold,
  input  logic [CHWIDTH-1:0]        cRowId,
  output logic [CNT_W-1:0]          hit_cnt,
  output logic [CNT_W-1:0]          miss_cnt
);

  localparam int unsigned IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WIN_W = $clog2(CHECK_WIN + 1);
  localparam int unsigned LAT_W = $clog2(MISS_LAT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHECK_WIN - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MISS_LAT - 1);

  state_t state, state_d;

  logic [NREQ-1:0]      arb_gnt_c;
  logic [IDXW-1:0]      arb_idx_c;
  logic                 arb_any_c;
  logic                 adv_c;

  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 we_q, we_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [CHWIDTH-1:0]   crow_q, crow_d;
  logic                 miss_q, miss_d;

  logic [NREQ-1:0]      gnt_d, done_d;
  logic                 rd_d, wr_d, sync_d, rsp_miss_d;
  logic [ADDRWIDTH-1:0] rowid_d;
  logic [CHWIDTH-1:0]   rsp_crow_d;
  logic [CNT_W-1:0]     hit_cnt_d, miss_cnt_d;

  logic [ADDRWIDTH-1:0] row_arr [NREQ];

  // Unpack the flat per-requester row address bus.
  for (genvar g = 0; g < NREQ; g++) begin : g_row
    assign row_arr[g] = req_row[g*ADDRWIDTH +: ADDRWIDTH];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .adv     (adv_c),
    .adv_idx (idx_q),
    .gnt_c   (arb_gnt_c),
    .idx_c   (arb_idx_c),
    .any_c   (arb_any_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (arb_any_c) state_d = ISSUE;
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (hold)                 state_d = MISS;
        else if (win_q == WIN_LAST) state_d = DONE;
      end
      MISS:  if (lat_q == LAT_LAST) state_d = FILL;
      FILL:  if (!hold) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, everything else holds.
  always_comb begin
    gnt_d      = '0;
    done_d     = '0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    sync_d     = (state_d == FILL);
    rowid_d    = RowId;
    rsp_crow_d = rsp_crow;
    rsp_miss_d = rsp_miss;
    hit_cnt_d  = hit_cnt;
    miss_cnt_d = miss_cnt;
    idx_d      = idx_q;
    we_d       = we_q;
    win_d      = win_q;
    lat_d      = lat_q;
    crow_d     = crow_q;
    miss_d     = miss_q;
    adv_c      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any_c) begin
          gnt_d   = arb_gnt_c;
          idx_d   = arb_idx_c;
          we_d    = req_we[arb_idx_c];
          rowid_d = row_arr[arb_idx_c];
        end
      end
      ISSUE: begin
        rd_d  = ~we_q;
        wr_d  = we_q;
        win_d = '0;
      end
      CHECK: begin
        if (hold) begin
          lat_d = '0;
        end else if (win_q == WIN_LAST) begin
          crow_d = cRowId;
          miss_d = 1'b0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      MISS: lat_d = lat_q + LAT_W'(1);
      FILL: begin
        if (!hold) begin
          crow_d = cRowId;
          miss_d = 1'b1;
        end
      end
      DONE: begin
        done_d[idx_q] = 1'b1;
        rsp_crow_d    = crow_q;
        rsp_miss_d    = miss_q;
        adv_c         = 1'b1;
        if (miss_q) miss_cnt_d = sat_inc(miss_cnt);
        else        hit_cnt_d  = sat_inc(hit_cnt);
      end
      default: ;
    endcase
  end

  // Registered outputs and transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      done     <= '0;
      RD       <= 1'b0;
      WR       <= 1'b0;
      sync     <= 1'b0;
      RowId    <= '0;
      rsp_crow <= '0;
      rsp_miss <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      win_q    <= '0;
      lat_q    <= '0;
      crow_q   <= '0;
      miss_q   <= 1'b0;
    end else begin
      gnt      <= gnt_d;
      done     <= done_d;
      RD       <= rd_d;
      WR       <= wr_d;
      sync     <= sync_d;
      RowId    <= rowid_d;
      rsp_crow <= rsp_crow_d;
      rsp_miss <= rsp_miss_d;
      hit_cnt  <= hit_cnt_d;
      miss_cnt <= miss_cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      win_q    <= win_d;
      lat_q    <= lat_d;
      crow_q   <= crow_d;
      miss_q   <= miss_d;
    end
  end

endmodule

// File: tb/tb_cache_sched.sv
// Self-checking bench for cache_sched with a stub row cache and a scoreboard.
module tb_cache_sched;

  localparam int NREQ = 4;
  localparam int AW   = 17;
  localparam int CW   = 5;
  localparam int MLAT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_we;
  logic [NREQ*AW-1:0] req_row;
  logic [NREQ-1:0]   gnt, done;
  logic [CW-1:0]     rsp_crow;
  logic              rsp_miss, RD, WR, sync, hold;
  logic [AW-1:0]     RowId;
  logic [CW-1:0]     cRowId;
  logic [15:0]       hit_cnt, miss_cnt;

  cache_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_row(req_row),
    .gnt(gnt), .done(done), .rsp_crow(rsp_crow), .rsp_miss(rsp_miss),
    .RD(RD), .WR(WR), .RowId(RowId), .sync(sync), .hold(hold),
    .cRowId(cRowId), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    int         idx;
    bit         we;
    logic [16:0] row;
    bit         miss;
    int         dly;
    logic [4:0] crow;
    int         lat;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] crow;
    bit         miss;
  } rsp_t;

  rsp_t exp_q[$];
  int   gnt_exp_q[$];
  int   exp_hit = 0;
  int   exp_miss = 0;

  // Stub row cache: on a command in miss mode, raise hold after stub_dly
  // cycles and drop it one cycle after sync is seen.
  bit stub_miss = 1'b0;
  int stub_dly  = 0;
  int hold_cyc  = -100;
  int sync_cyc  = -100;

  initial begin : stub
    int n;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_miss && rst_n && (RD || WR)) begin
        repeat (stub_dly) @(negedge clk);
        hold     = 1'b1;
        hold_cyc = cyc;
        n = 0;
        while (!sync && n < 200 && rst_n) begin
          @(negedge clk);
          n++;
        end
        sync_cyc = cyc;
        @(negedge clk);
        hold = 1'b0;
      end
    end
  end

  // Scoreboard: every gnt/done pulse is matched against the expected queues.
  always @(negedge clk) begin : mon
    int   ge;
    rsp_t re;
    logic [NREQ-1:0] oh;
    if (rst_n) begin
      if (gnt != '0) begin
        if (gnt_exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else begin
          ge = gnt_exp_q.pop_front();
          oh = '0;
          oh[ge] = 1'b1;
          chk("gnt_order", 32'(gnt), 32'(oh));
        end
      end
      if (done != '0) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          re = exp_q.pop_front();
          oh = '0;
          oh[re.idx] = 1'b1;
          chk("done_idx", 32'(done), 32'(oh));
          chk("rsp_crow", 32'(rsp_crow), 32'(re.crow));
          chk("rsp_miss", 32'(rsp_miss), 32'(re.miss));
        end
      end
      if (RD || WR) chk("rd_wr_exclusive", 32'(RD && WR), 0);
    end
  end

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One isolated transaction from a single requester.
  task automatic apply(input vec_t v);
    int n;
    int g_cyc;
    stub_miss = v.miss;
    stub_dly  = v.dly;
    cRowId    = v.crow;
    hold_cyc  = -100;
    sync_cyc  = -100;
    gnt_exp_q.push_back(v.idx);
    exp_q.push_back('{idx: v.idx, crow: v.crow, miss: v.miss});
    req_we[v.idx]           = v.we;
    req_row[v.idx*AW +: AW] = v.row;
    req[v.idx]              = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 50);
    chk("gnt_seen", 32'(|gnt), 1);
    g_cyc = cyc;
    chk("rowid_at_gnt", 32'(RowId), 32'(v.row));
    @(negedge clk);
    chk("rd_after_gnt", 32'(RD), 32'(!v.we));
    chk("wr_after_gnt", 32'(WR), 32'(v.we));
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 60);
    chk("done_seen", 32'(|done), 1);
    chk("latency", cyc - g_cyc, v.lat);
    chk("rowid_stable", 32'(RowId), 32'(v.row));
    chk("sync_low_at_done", 32'(sync), 0);
    if (v.miss) begin
      exp_miss = sat16(exp_miss);
      // hold driven during cycle c is first acted on from cycle c+1
      chk("sync_delay", sync_cyc - (hold_cyc + 1), MLAT);
    end else begin
      exp_hit = sat16(exp_hit);
    end
    chk("hit_cnt", 32'(hit_cnt), exp_hit);
    chk("miss_cnt", 32'(miss_cnt), exp_miss);
    req[v.idx] = 1'b0;
  endtask

  // Wait for a number of done pulses, releasing each requester as it completes.
  task automatic drain(input int ndone);
    int seen = 0;
    int n = 0;
    while (seen < ndone && n < 200) begin
      @(negedge clk);
      n++;
      if (done != '0) begin
        seen++;
        req = req & ~done;
      end
    end
    chk("drain_count", seen, ndone);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[6];

  initial begin : main
    vec_t v;
    int seen, n, last_g;

    tbl[0] = '{idx: 0, we: 0, row: 17'h00123, miss: 0, dly: 0, crow: 5'd7,  lat: 5};
    tbl[1] = '{idx: 2, we: 1, row: 17'h1ABCD, miss: 1, dly: 2, crow: 5'h11, lat: 15};
    tbl[2] = '{idx: 1, we: 0, row: 17'h0F0F0, miss: 1, dly: 0, crow: 5'h03, lat: 13};
    tbl[3] = '{idx: 0, we: 0, row: 17'h0AAAA, miss: 0, dly: 0, crow: 5'h00, lat: 5};
    tbl[4] = '{idx: 1, we: 1, row: 17'h1FFFF, miss: 1, dly: 1, crow: 5'h15, lat: 14};
    tbl[5] = '{idx: 3, we: 1, row: 17'h00001, miss: 0, dly: 0, crow: 5'h1F, lat: 5};

    rst_n   = 1'b0;
    req     = '0;
    req_we  = '0;
    req_row = '0;
    cRowId  = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(RD), 0);
    chk("rst_wr", 32'(WR), 0);
    chk("rst_sync", 32'(sync), 0);
    chk("rst_rsp_miss", 32'(rsp_miss), 0);
    chk("rst_rsp_crow", 32'(rsp_crow), 0);
    chk("rst_rowid", 32'(RowId), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) apply(tbl[i]);

    // Round robin: all four held high, hits; pointer is 0 after requester 3.
    stub_miss = 1'b0;
    cRowId    = 5'h0A;
    req_we    = '0;
    for (int i = 0; i < 5; i++) begin
      gnt_exp_q.push_back(i % 4);
      exp_q.push_back('{idx: i % 4, crow: 5'h0A, miss: 1'b0});
    end
    req = '1;
    seen = 0;
    n = 0;
    last_g = -1;
    while (seen < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt != '0) begin
        if (last_g >= 0) chk("rr_spacing", cyc - last_g, 6);
        last_g = cyc;
      end
      if (done != '0) begin
        seen++;
        if (seen == 5) req = '0;
      end
    end
    chk("rr_count", seen, 5);
    for (int i = 0; i < 5; i++) exp_hit = sat16(exp_hit);
    chk("rr_hit_cnt", 32'(hit_cnt), exp_hit);

    // Priority pointer: after requester 1, requester 3 beats requester 0.
    v = '{idx: 1, we: 0, row: 17'h00042, miss: 0, dly: 0, crow: 5'h02, lat: 5};
    apply(v);
    cRowId = 5'h0C;
    gnt_exp_q.push_back(3);
    gnt_exp_q.push_back(0);
    exp_q.push_back('{idx: 3, crow: 5'h0C, miss: 1'b0});
    exp_q.push_back('{idx: 0, crow: 5'h0C, miss: 1'b0});
    req_we = '0;
    req[0] = 1'b1;
    req[3] = 1'b1;
    drain(2);
    exp_hit = sat16(sat16(exp_hit));
    chk("prio_hit_cnt", 32'(hit_cnt), exp_hit);

    // Counter saturation: preload just below the ceiling, then two more hits.
    force dut.hit_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt;
    exp_hit = 65534;
    @(negedge clk);
    chk("hit_preload", 32'(hit_cnt), exp_hit);
    v = '{idx: 1, we: 0, row: 17'h01000, miss: 0, dly: 0, crow: 5'h09, lat: 5};
    apply(v);
    v = '{idx: 2, we: 1, row: 17'h02000, miss: 0, dly: 0, crow: 5'h0B, lat: 5};
    apply(v);
    chk("hit_saturated", 32'(hit_cnt), 65535);

    // Reset while the miss latency is being counted.
    stub_miss = 1'b1;
    stub_dly  = 0;
    cRowId    = 5'h13;
    gnt_exp_q.push_back(2);
    req_we[2] = 1'b0;
    req[2]    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 50);
    chk("abort_gnt_seen", 32'(|gnt), 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sync", 32'(sync), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_rowid", 32'(RowId), 0);
    chk("abort_hit_cnt", 32'(hit_cnt), 0);
    chk("abort_miss_cnt", 32'(miss_cnt), 0);
    req       = '0;
    stub_miss = 1'b0;
    exp_hit   = 0;
    exp_miss  = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(gnt | done), 0);
    cRowId = 5'h04;
    gnt_exp_q.push_back(0);
    gnt_exp_q.push_back(3);
    exp_q.push_back('{idx: 0, crow: 5'h04, miss: 1'b0});
    exp_q.push_back('{idx: 3, crow: 5'h04, miss: 1'b0});
    req_we = '0;
    req[0] = 1'b1;
    req[3] = 1'b1;
    drain(2);
    exp_hit = sat16(sat16(exp_hit));
    chk("post_rst_hit_cnt", 32'(hit_cnt), exp_hit);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size() + gnt_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
